// File: rtl/nibble_pkg.sv
// ---------------------------------------------------------------------------
// nibble_pkg
// Shared constants for the nibble sequencer: opcodes, ALU select codes,
// FSM state encoding and small decode helpers used by both the sequencer
// and its decoder.
// ---------------------------------------------------------------------------
package nibble_pkg;

    // Opcodes live in ir[7:4]; ir[3:0] carries the immediate nibble.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_JC    = 4'h1;
    localparam logic [3:0] OP_JNC   = 4'h2;
    localparam logic [3:0] OP_JZ    = 4'h3;
    localparam logic [3:0] OP_JNZ   = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h5;
    localparam logic [3:0] OP_CMPI  = 4'h6;
    localparam logic [3:0] OP_LIT   = 4'h7;
    localparam logic [3:0] OP_ADDI  = 4'h8;
    localparam logic [3:0] OP_NANDI = 4'h9;
    localparam logic [3:0] OP_OUT   = 4'hA;
    localparam logic [3:0] OP_HLT   = 4'hF;

    // ALU select codes driven on alu_sel.
    localparam logic [2:0] ALU_ST    = 3'd0;
    localparam logic [2:0] ALU_COMPI = 3'd1;
    localparam logic [2:0] ALU_LIT   = 3'd2;
    localparam logic [2:0] ALU_ADDI  = 3'd3;
    localparam logic [2:0] ALU_NANDI = 3'd4;

    // FSM state encoding.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_ADDR  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Two-byte instructions: the second byte is the low half of the target.
    function automatic logic is_jump(input logic [3:0] op);
        return (op >= OP_JC) && (op <= OP_JMP);
    endfunction

    // Only the ALU instructions leave meaningful carry/zero flags behind.
    function automatic logic is_alu(input logic [3:0] op);
        return (op >= OP_CMPI) && (op <= OP_NANDI);
    endfunction

    // flags: [0] carry, [1] zero.
    function automatic logic jump_taken(input logic [3:0] op, input logic [1:0] flags);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_JC:   taken = flags[0];
            OP_JNC:  taken = ~flags[0];
            OP_JZ:   taken = flags[1];
            OP_JNZ:  taken = ~flags[1];
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/nibble_decoder.sv
// ---------------------------------------------------------------------------
// nibble_decoder
// Purely combinational decode of the instruction register into the ALU and
// bus-driver controls. Everything is forced to zero unless the sequencer is
// actively executing (EXEC state with run high).
//
// Ports:
//   exec_active  in   1  sequencer is in EXEC and run=1
//   ir           in   8  instruction register {opcode, nibble}
//   oprnd        out  4  immediate nibble for the operand bus driver
//   alu_sel      out  3  ALU select code
//   oprnd_en     out  1  operand bus driver enable
//   accu_en      out  1  accumulator enable
//   out_en       out  1  output bus driver enable
// ---------------------------------------------------------------------------
module nibble_decoder
    import nibble_pkg::*;
(
    input  logic       exec_active,
    input  logic [7:0] ir,
    output logic [3:0] oprnd,
    output logic [2:0] alu_sel,
    output logic       oprnd_en,
    output logic       accu_en,
    output logic       out_en
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave one unassigned, which would infer a latch.
        oprnd    = 4'h0;
        alu_sel  = ALU_ST;
        oprnd_en = 1'b0;
        accu_en  = 1'b0;
        out_en   = 1'b0;
        if (exec_active) begin
            case (ir[7:4])
                OP_CMPI: begin
                    // Compare only sets flags; the accumulator keeps its value.
                    alu_sel  = ALU_COMPI;
                    oprnd    = ir[3:0];
                    oprnd_en = 1'b1;
                end
                OP_LIT: begin
                    alu_sel  = ALU_LIT;
                    oprnd    = ir[3:0];
                    oprnd_en = 1'b1;
                    accu_en  = 1'b1;
                end
                OP_ADDI: begin
                    alu_sel  = ALU_ADDI;
                    oprnd    = ir[3:0];
                    oprnd_en = 1'b1;
                    accu_en  = 1'b1;
                end
                OP_NANDI: begin
                    alu_sel  = ALU_NANDI;
                    oprnd    = ir[3:0];
                    oprnd_en = 1'b1;
                    accu_en  = 1'b1;
                end
                OP_OUT: begin
                    alu_sel = ALU_ST;
                    oprnd   = ir[3:0];
                    out_en  = 1'b1;
                end
                // NOP, HLT and the unused opcodes drive nothing.
                OP_NOP, OP_HLT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/nibble_sequencer.sv
// ---------------------------------------------------------------------------
// nibble_sequencer
// Program sequencer for a 4-bit ALU datapath. Fetches one byte per cycle from
// a combinational program ROM, executes single-byte ALU/OUT instructions in
// one EXEC cycle, and resolves two-byte conditional jumps in one ADDR cycle.
// run=0 freezes all state; HLT parks the machine until reset.
//
// Ports:
//   clock      in   1   rising-edge system clock
//   reset      in   1   asynchronous, active-high reset
//   run        in   1   1 = advance, 0 = stall with state held
//   prog_byte  in   8   ROM data at address pc
//   flags      in   2   ALU flags: [0] carry, [1] zero
//   pc         out  12  program counter / ROM address
//   oprnd      out  4   immediate nibble to operand bus driver
//   alu_sel    out  3   ALU select code
//   oprnd_en   out  1   operand bus driver enable
//   accu_en    out  1   accumulator enable
//   out_en     out  1   output bus driver enable
//   halted     out  1   high while in HALT
// ---------------------------------------------------------------------------
module nibble_sequencer
    import nibble_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  prog_byte,
    input  logic [1:0]  flags,
    output logic [11:0] pc,
    output logic [3:0]  oprnd,
    output logic [2:0]  alu_sel,
    output logic        oprnd_en,
    output logic        accu_en,
    output logic        out_en,
    output logic        halted
);

    logic [1:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  ir_q, ir_d;
    logic [1:0]  flags_q, flags_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        if (run) begin
            case (state_q)
                ST_FETCH: begin
                    ir_d    = prog_byte;
                    pc_d    = pc_q + 12'd1;   // wraps 0xFFF -> 0x000
                    state_d = is_jump(prog_byte[7:4]) ? ST_ADDR : ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_alu(ir_q[7:4])) begin
                        flags_d = flags;
                    end
                    state_d = (ir_q[7:4] == OP_HLT) ? ST_HALT : ST_FETCH;
                end
                ST_ADDR: begin
                    // prog_byte here is the low target byte at pc; skipping it
                    // on fall-through also wraps at the top of memory.
                    if (jump_taken(ir_q[7:4], flags_q)) begin
                        pc_d = {ir_q[3:0], prog_byte};
                    end else begin
                        pc_d = pc_q + 12'd1;
                    end
                    state_d = ST_FETCH;
                end
                default: ;  // ST_HALT: hold everything until reset
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= 12'h000;
            ir_q    <= 8'h00;
            flags_q <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == ST_HALT);

    nibble_decoder u_decoder (
        .exec_active (run && (state_q == ST_EXEC)),
        .ir          (ir_q),
        .oprnd       (oprnd),
        .alu_sel     (alu_sel),
        .oprnd_en    (oprnd_en),
        .accu_en     (accu_en),
        .out_en      (out_en)
    );

endmodule

// File: tb/tb_nibble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nibble_sequencer
// Directed bench for nibble_sequencer. A 4 KiB program ROM array feeds
// prog_byte combinationally from pc; each scenario loads a short program,
// resets, and steps the clock one edge at a time, checking outputs 1 time
// unit after each rising edge against hand-computed values.
// ---------------------------------------------------------------------------
module tb_nibble_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run   = 1'b1;
    logic [7:0]  prog_byte;
    logic [1:0]  flags = 2'b00;
    logic [11:0] pc;
    logic [3:0]  oprnd;
    logic [2:0]  alu_sel;
    logic        oprnd_en, accu_en, out_en, halted;

    logic [7:0]  rom [0:4095];
    int          n_checks = 0;
    int          n_pass   = 0;

    assign prog_byte = rom[pc];

    always #5 clock = ~clock;

    nibble_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .prog_byte (prog_byte),
        .flags     (flags),
        .pc        (pc),
        .oprnd     (oprnd),
        .alu_sel   (alu_sel),
        .oprnd_en  (oprnd_en),
        .accu_en   (accu_en),
        .out_en    (out_en),
        .halted    (halted)
    );

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // All control outputs quiet (alu_sel, oprnd, enables).
    task automatic check_idle(input string tag);
        check({tag, ".alu_sel"}, 12'(alu_sel), 12'd0);
        check({tag, ".oprnd"},   12'(oprnd),   12'd0);
        check({tag, ".enables"}, 12'({oprnd_en, accu_en, out_en}), 12'd0);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    // Hold reset across a rising edge, release it mid-cycle.
    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b1;
        flags = 2'b00;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_rom();

        // ---------------- reset state ----------------
        rom[0] = 8'h75;
        @(negedge clock);
        check("rst.pc", pc, 12'h000);
        check("rst.halted", 12'(halted), 12'd0);
        check_idle("rst");

        // ---------------- LIT 5 / ADDI 3 / OUT ----------------
        clear_rom();
        rom[0] = 8'h75; rom[1] = 8'h83; rom[2] = 8'hA0;
        do_reset();
        step();  // cycle 1 FETCH done -> EXEC LIT
        check("lit.alu_sel", 12'(alu_sel), 12'd2);
        check("lit.oprnd", 12'(oprnd), 12'd5);
        check("lit.oprnd_en", 12'(oprnd_en), 12'd1);
        check("lit.accu_en", 12'(accu_en), 12'd1);
        check("lit.out_en", 12'(out_en), 12'd0);
        check("lit.pc", pc, 12'h001);
        step();  // back in FETCH
        check_idle("fetch2");
        step();  // EXEC ADDI
        check("addi.alu_sel", 12'(alu_sel), 12'd3);
        check("addi.oprnd", 12'(oprnd), 12'd3);
        check("addi.accu_en", 12'(accu_en), 12'd1);
        step();
        step();  // EXEC OUT
        check("out.out_en", 12'(out_en), 12'd1);
        check("out.alu_sel", 12'(alu_sel), 12'd0);
        check("out.oprnd_en", 12'(oprnd_en), 12'd0);
        check("out.accu_en", 12'(accu_en), 12'd0);
        check("out.pc", pc, 12'h003);
        step();
        check("after_out.pc", pc, 12'h003);
        check("after_out.out_en", 12'(out_en), 12'd0);

        // ---------------- JMP 0x123 ----------------
        clear_rom();
        rom[0] = 8'h51; rom[1] = 8'h23; rom[12'h123] = 8'h74;
        do_reset();
        step();  // FETCH JMP -> ADDR
        check("jmp.addr_pc", pc, 12'h001);
        check_idle("jmp.addr");
        check("jmp.addr_halted", 12'(halted), 12'd0);
        step();
        check("jmp.pc", pc, 12'h123);
        step();  // fetched LIT 4 from 0x123
        check("jmp.target_alu_sel", 12'(alu_sel), 12'd2);
        check("jmp.target_oprnd", 12'(oprnd), 12'd4);
        check("jmp.target_pc", pc, 12'h124);

        // ---------------- ADDI, carry set, JC taken ----------------
        clear_rom();
        rom[0] = 8'h81; rom[1] = 8'h10; rom[2] = 8'h40;
        do_reset();
        step();            // EXEC ADDI
        flags = 2'b01;
        step();            // flags captured
        flags = 2'b00;     // must not be recaptured outside EXEC
        step();            // FETCH JC -> ADDR
        check("jc_t.addr_pc", pc, 12'h002);
        step();
        check("jc_t.pc", pc, 12'h040);

        // ---------------- ADDI, carry clear, JC falls through ----------------
        do_reset();
        step();
        flags = 2'b00;
        step();
        flags = 2'b01;
        step();
        step();
        check("jc_nt.pc", pc, 12'h003);

        // ---------------- CMPI zero, NOP keeps flags, JZ taken ----------------
        clear_rom();
        rom[0] = 8'h60; rom[1] = 8'h00; rom[2] = 8'h30; rom[3] = 8'h80;
        do_reset();
        step();            // EXEC CMPI
        check("cmpi.alu_sel", 12'(alu_sel), 12'd1);
        check("cmpi.oprnd_en", 12'(oprnd_en), 12'd1);
        check("cmpi.accu_en", 12'(accu_en), 12'd0);
        flags = 2'b10;
        step();            // flags_q = zero
        flags = 2'b00;
        step();            // EXEC NOP, flags must not be captured
        check_idle("nop");
        step();
        step();            // FETCH JZ -> ADDR
        step();
        check("jz.pc", pc, 12'h080);

        // ---------------- stall during EXEC of ADDI ----------------
        clear_rom();
        rom[0] = 8'h87;
        do_reset();
        step();            // EXEC ADDI
        run = 1'b0;
        #1;
        check_idle("stall");
        step(); step(); step();
        check("stall.pc", pc, 12'h001);
        check_idle("stall3");
        run = 1'b1;
        #1;
        check("resume.alu_sel", 12'(alu_sel), 12'd3);
        check("resume.accu_en", 12'(accu_en), 12'd1);
        check("resume.oprnd", 12'(oprnd), 12'd7);
        step();            // EXEC consumed exactly once
        check("resume.fetch_accu_en", 12'(accu_en), 12'd0);
        check("resume.fetch_pc", pc, 12'h001);
        run = 1'b0;
        step();            // stall in FETCH
        check("stall_fetch.pc", pc, 12'h001);
        run = 1'b1;

        // ---------------- JMP 0xFFF holding NOP: increment wrap ----------------
        clear_rom();
        rom[0] = 8'h5F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h00;
        do_reset();
        step(); step();
        check("wrap.jmp_pc", pc, 12'hFFF);
        step();            // FETCH NOP at 0xFFF
        check("wrap.pc", pc, 12'h000);

        // ---------------- JC not taken at 0xFFE: fall-through wrap ----------------
        clear_rom();
        rom[0] = 8'h5F; rom[1] = 8'hFE; rom[12'hFFE] = 8'h1A; rom[12'hFFF] = 8'hBC;
        do_reset();
        step(); step();    // pc = 0xFFE
        step();            // FETCH JC -> ADDR, pc = 0xFFF
        check("ft_wrap.addr_pc", pc, 12'hFFF);
        step();
        check("ft_wrap.pc", pc, 12'h000);

        // ---------------- HLT ----------------
        clear_rom();
        rom[0] = 8'hF0;
        do_reset();
        step();            // EXEC HLT
        check("hlt.exec_halted", 12'(halted), 12'd0);
        step();
        check("hlt.halted", 12'(halted), 12'd1);
        check("hlt.pc", pc, 12'h001);
        check_idle("hlt");
        step(); step(); step();
        check("hlt.pc_held", pc, 12'h001);
        check("hlt.halted_held", 12'(halted), 12'd1);

        // ---------------- async reset during ADDR ----------------
        clear_rom();
        rom[0] = 8'h5A; rom[1] = 8'hBC;
        do_reset();
        step();            // in ADDR, pc = 1
        check("areset.addr_pc", pc, 12'h001);
        #2 reset = 1'b1;   // mid-cycle, no clock edge
        #1;
        check("areset.pc", pc, 12'h000);
        check("areset.halted", 12'(halted), 12'd0);
        check_idle("areset");
        @(negedge clock);
        reset = 1'b0;
        step();            // first fetch from 0x000 is the JMP again
        check("areset.refetch_pc", pc, 12'h001);
        step();
        check("areset.jmp_pc", pc, 12'hABC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
